databus_arbiter: RTL and testbench
==================================

Name: databus_arbiter

Overview:
- Parametrised successor to the 8-way data bus multiplexer: N_SRC sources, WIDTH-bit data, with a registered output.
- Two modes: direct (external select) and arbitrated (round-robin request/grant with a bounded hold time).
- Sits between the register/ALU/memory sources and every bus consumer.
- Owns bus ownership and tells each source when its data is on the bus.

Parameters:
- WIDTH, 8, data width of each source and of the bus.
- N_SRC, 8, number of sources; must be >= 2.
- SEL_W, $clog2(N_SRC), width of the select and owner indices.
- MAX_HOLD, 15, cycles an owner may keep the bus while another source is requesting; must be >= 1.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- mode  in  1  0 = direct select, 1 = round-robin arbitration.
- sel  in  SEL_W  source index used in direct mode.
- req  in  N_SRC  per-source bus request, used in arbitration mode.
- data_in  in  N_SRC*WIDTH  flattened source data; source i occupies bits [i*WIDTH +: WIDTH].
- bus_out  out  WIDTH  registered bus value.
- bus_valid  out  1  bus_out carries data from a granted source.
- grant  out  N_SRC  one-hot owner; all zero when the bus is idle.
- owner  out  SEL_W  binary index of the current owner; holds its last value when idle.

Behaviour:
- Reset (asynchronous, rst_n low):
  - Outputs: bus_out=0, bus_valid=0, grant=0, owner=0.
  - Internal state: state=IDLE, rr_ptr=0, hold_cnt=0.
  - Effective immediately; reset mid-ownership drops the grant with no handshake.
- Next-owner selection: all outputs update on the same edge from one next-owner decision.
  - bus_out <= data_in[next_owner] on that edge, so bus_out, grant and owner always refer to the same source.
  - Latency: one cycle from sel/req change to output.
- Direct mode (mode=0):
  - Every edge: next_owner=sel, grant=onehot(sel), bus_valid=1, state forced to IDLE, hold_cnt=0.
  - sel >= N_SRC: bus_out=0, bus_valid=0, grant=0, owner unchanged.
  - rr_ptr is not modified.
- Arbitration mode (mode=1), two states: IDLE and OWNED.
- IDLE:
  - req==0: stay IDLE; grant=0, bus_valid=0, bus_out holds its last value.
  - Any req bit set: pick the first requester scanning cyclically from rr_ptr upward (wrapping N_SRC-1 -> 0); go to OWNED, hold_cnt=0, rr_ptr=winner+1 mod N_SRC.
- OWNED, at each edge:
  - req[owner]=0: release. Re-arbitrate among the others from rr_ptr in the same edge, with no idle bubble; if none is requesting, go to IDLE with grant=0, bus_valid=0.
  - req[owner]=1, another req pending, and hold_cnt==MAX_HOLD: forced rotation. Pick the next requester from rr_ptr (excluding the owner); hold_cnt=0.
  - Otherwise: keep the owner; bus_out refreshes with data_in[owner] each cycle; hold_cnt increments, saturating at MAX_HOLD.
  - Owner alone requesting: holds the bus indefinitely, with no rotation.
- Mode switching:
  - Mode change takes effect at the next edge.
  - 1->0: ownership is abandoned; direct behaviour starts that edge.
  - 0->1: starts from IDLE using the preserved rr_ptr.
- Simultaneous requests: exactly one grant, chosen by round-robin order; never more than one grant bit set.
- Invariants:
  - bus_valid == |grant.
  - When bus_valid=1, owner == index of the set grant bit.

Decomposition:
- Shared package bus_pkg holds:
  - MODE_DIRECT / MODE_ARB constants.
  - arb_state_t enum (IDLE, OWNED).
  - The default WIDTH/N_SRC constants shared with the rest of the datapath.
- One sub-module: rr_picker. It is combinational; given a request vector, a start pointer and an exclude mask, it returns found and a winner index.
- The FSM, hold counter and output registers stay in the top module.

Test Plan (N_SRC=8, WIDTH=8, MAX_HOLD=3; source i drives 8'h10+i):
- Reset: rst_n low mid-ownership -> bus_out=0, bus_valid=0, grant=0 at once; after release with mode=1, req=0 -> outputs stay 0.
- Direct mode: sel=5 -> next edge bus_out=8'h15, grant=8'b0010_0000, owner=5, bus_valid=1; sel=5 then 2 on consecutive cycles -> outputs follow with 1-cycle latency.
- Round robin: mode=1, req=8'b1000_0101 held, each owner dropping req for one cycle after it is granted -> grant order 0, 2, 7, 0; owner wraps 7->0.
- Hold limit: req=8'b0000_0011 constant -> owner 0 holds 4 cycles (hold_cnt reaches 3), then owner 1 for 4 cycles, alternating; bus_out toggles 8'h10/8'h11 accordingly.
- Release without bubble: owner 3 drops req while req[6]=1 -> next edge grant=8'b0100_0000, bus_valid stays 1, bus_out=8'h16; all req drop -> grant=0, bus_valid=0.
- Mode switch: while owner 4 holds in mode=1, set mode=0, sel=1 -> next edge grant=8'b0000_0010; back to mode=1 with req=8'b0001_0000 -> arbitration restarts from the preserved rr_ptr=5, scanning 5,6,7,0..4 -> grants source 4.

Source files
------------

// File: rtl/bus_pkg.sv
// bus_pkg: shared datapath constants, bus mode encodings and arbiter state type
package bus_pkg;
  localparam int BUS_WIDTH = 8;
  localparam int BUS_N_SRC = 8;
  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_ARB = 1'b1;
  typedef enum logic {IDLE, OWNED} arb_state_t;
endpackage

// File: rtl/databus_arbiter_if.sv
// databus_arbiter_if: source-side inputs and bus-side outputs of the data bus arbiter
// master: drives mode/sel/req/data_in, observes bus_out/bus_valid/grant/owner
// slave:  the arbiter itself
interface databus_arbiter_if
  import bus_pkg::*;
#(
  parameter int WIDTH = BUS_WIDTH,
  parameter int N_SRC = BUS_N_SRC,
  parameter int SEL_W = $clog2(N_SRC)
);
  logic mode;
  logic [SEL_W-1:0] sel;
  logic [N_SRC-1:0] req;
  logic [N_SRC*WIDTH-1:0] data_in;
  logic [WIDTH-1:0] bus_out;
  logic bus_valid;
  logic [N_SRC-1:0] grant;
  logic [SEL_W-1:0] owner;
  modport master(output mode, sel, req, data_in, input bus_out, bus_valid, grant, owner);
  modport slave(input mode, sel, req, data_in, output bus_out, bus_valid, grant, owner);
endinterface

// File: rtl/databus_arbiter_rr_picker.sv
// rr_picker: first set bit of req & ~excl, scanning cyclically upward from start
// in:  req, excl (N_SRC), start (SEL_W)
// out: found, idx (winner index, 0 when nothing found)
module rr_picker #(
  parameter int N_SRC = 8,
  parameter int SEL_W = $clog2(N_SRC)
) (
  input  logic [N_SRC-1:0] req,
  input  logic [N_SRC-1:0] excl,
  input  logic [SEL_W-1:0] start,
  output logic             found,
  output logic [SEL_W-1:0] idx
);
  logic [N_SRC-1:0] cand;
  assign cand = req & ~excl;
  // scan from the far end back toward start so the closest candidate is the last write
  always_comb begin
    logic [SEL_W-1:0] j;
    found = 1'b0;
    idx = '0;
    j = '0;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      j = SEL_W'((int'(start) + k) % N_SRC);
      if (cand[j]) begin
        found = 1'b1;
        idx = j;
      end
    end
  end
endmodule

// File: rtl/databus_arbiter.sv
// databus_arbiter: registered N_SRC-way bus mux with direct select or round-robin arbitration
// clk, rst_n (async, active-low)
// bus.mode/sel/req/data_in in; bus.bus_out/bus_valid/grant/owner registered out
module databus_arbiter
  import bus_pkg::*;
#(
  parameter int WIDTH    = BUS_WIDTH,
  parameter int N_SRC    = BUS_N_SRC,
  parameter int SEL_W    = $clog2(N_SRC),
  parameter int MAX_HOLD = 15
) (
  input logic clk,
  input logic rst_n,
  databus_arbiter_if.slave bus
);
  localparam int HW = $clog2(MAX_HOLD + 1);
  arb_state_t state, state_n;
  logic [SEL_W-1:0] rr_ptr, rr_n, owner_n, win;
  logic [HW-1:0] hold_cnt, hold_n;
  logic [N_SRC-1:0] own_mask, excl;
  logic [WIDTH-1:0] out_n;
  logic found, own_req, others, pick, valid_n;
  assign own_mask = N_SRC'(1) << bus.owner;
  assign excl = (state == OWNED) ? own_mask : '0;
  rr_picker #(.N_SRC(N_SRC), .SEL_W(SEL_W)) u_pick (
    .req(bus.req),
    .excl(excl),
    .start(rr_ptr),
    .found(found),
    .idx(win)
  );
  // one decision drives every output so bus_out, grant and owner always agree
  always_comb begin
    own_req = bus.req[bus.owner];
    others = |(bus.req & ~own_mask);
    pick = state == IDLE || !own_req || (others && hold_cnt == HW'(MAX_HOLD));
    state_n = state;
    rr_n = rr_ptr;
    hold_n = hold_cnt;
    owner_n = bus.owner;
    valid_n = 1'b0;
    if (bus.mode != MODE_ARB) begin
      state_n = IDLE;
      hold_n = '0;
      if (32'(bus.sel) < N_SRC) begin
        owner_n = bus.sel;
        valid_n = 1'b1;
      end
    end else if (pick) begin
      state_n = found ? OWNED : IDLE;
      if (found) begin
        owner_n = win;
        valid_n = 1'b1;
        hold_n = '0;
        rr_n = (win == SEL_W'(N_SRC - 1)) ? '0 : win + 1'b1;
      end
    end else begin
      valid_n = 1'b1;
      hold_n = (hold_cnt == HW'(MAX_HOLD)) ? hold_cnt : hold_cnt + 1'b1;
    end
    out_n = valid_n ? bus.data_in[int'(owner_n)*WIDTH +: WIDTH] :
            (bus.mode == MODE_ARB) ? bus.bus_out : '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rr_ptr <= '0;
      hold_cnt <= '0;
      bus.bus_out <= '0;
      bus.bus_valid <= 1'b0;
      bus.grant <= '0;
      bus.owner <= '0;
    end else begin
      state <= state_n;
      rr_ptr <= rr_n;
      hold_cnt <= hold_n;
      bus.bus_out <= out_n;
      bus.bus_valid <= valid_n;
      bus.grant <= valid_n ? N_SRC'(1) << owner_n : '0;
      bus.owner <= owner_n;
    end
  end
endmodule

// File: tb/tb_databus_arbiter.sv
// tb_databus_arbiter: directed plan plus randomized traffic against a spec-level model
module tb_databus_arbiter;
  import bus_pkg::*;
  localparam int MAX_HOLD = 3;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_pass = 0;
  int m_own, m_rr, m_hold, e_owner;
  logic [7:0] e_out;
  logic e_valid;
  databus_arbiter_if #(.WIDTH(8), .N_SRC(8)) ifc ();
  databus_arbiter #(.WIDTH(8), .N_SRC(8), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(ifc.slave)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask
  function automatic logic [7:0] src(input int i);
    return ifc.data_in[i*8 +: 8];
  endfunction
  function automatic int rr_pick(input logic [7:0] r, input int from, input int skip);
    for (int k = 0; k < 8; k++) begin
      int j;
      j = (from + k) % 8;
      if (r[j] && j != skip) return j;
    end
    return -1;
  endfunction
  task automatic model_reset();
    m_own = -1;
    m_rr = 0;
    m_hold = 0;
    e_owner = 0;
    e_out = 8'h00;
    e_valid = 1'b0;
  endtask
  // m_own = -1 means nobody holds the bus in arbitration mode
  task automatic model_edge();
    int w;
    logic [7:0] r;
    r = ifc.req;
    if (ifc.mode == MODE_DIRECT) begin
      m_own = -1;
      m_hold = 0;
      e_valid = 1'b1;
      e_owner = int'(ifc.sel);
      e_out = src(e_owner);
    end else begin
      w = -2;
      if (m_own < 0) w = rr_pick(r, m_rr, -1);
      else if (!r[m_own] || (m_hold == MAX_HOLD && (r & ~(8'd1 << m_own)) != 8'd0))
        w = rr_pick(r, m_rr, m_own);
      if (w == -2) m_hold = (m_hold < MAX_HOLD) ? m_hold + 1 : MAX_HOLD;
      else begin
        m_own = w;
        m_hold = 0;
        if (w >= 0) m_rr = (w + 1) % 8;
      end
      e_valid = m_own >= 0;
      if (e_valid) begin
        e_owner = m_own;
        e_out = src(m_own);
      end
    end
  endtask
  task automatic check_model(input string tag);
    check({tag, ".bus_out"}, 32'(ifc.bus_out), 32'(e_out));
    check({tag, ".valid"}, 32'(ifc.bus_valid), 32'(e_valid));
    check({tag, ".grant"}, 32'(ifc.grant), e_valid ? 32'(1) << e_owner : 32'd0);
    check({tag, ".owner"}, 32'(ifc.owner), 32'(e_owner));
  endtask
  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_model(tag);
  endtask
  task automatic expect_out(input string tag, input logic [7:0] o, input logic [7:0] g,
                            input int own, input logic v);
    check({tag, ".bus_out"}, 32'(ifc.bus_out), 32'(o));
    check({tag, ".grant"}, 32'(ifc.grant), 32'(g));
    check({tag, ".owner"}, 32'(ifc.owner), 32'(own));
    check({tag, ".valid"}, 32'(ifc.bus_valid), 32'(v));
  endtask
  initial begin
    logic [7:0] hold_seq [12];
    logic [7:0] rr_req [4];
    int rr_exp [4];
    model_reset();
    ifc.mode = MODE_DIRECT;
    ifc.sel = '0;
    ifc.req = '0;
    for (int i = 0; i < 8; i++) ifc.data_in[i*8 +: 8] = 8'h10 + 8'(i);
    #3;
    expect_out("reset", 8'h00, 8'h00, 0, 1'b0);
    #9 rst_n = 1'b1;
    #4;
    ifc.sel = 3'd5;
    step("dir5");
    expect_out("dir5c", 8'h15, 8'b0010_0000, 5, 1'b1);
    ifc.sel = 3'd2;
    step("dir2");
    expect_out("dir2c", 8'h12, 8'b0000_0100, 2, 1'b1);
    ifc.mode = MODE_ARB;
    ifc.req = 8'b0000_0011;
    hold_seq = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};
    for (int i = 0; i < 12; i++) begin
      step("hold");
      expect_out($sformatf("hold%0d", i), 8'h10 + hold_seq[i], 8'd1 << hold_seq[i],
                 int'(hold_seq[i]), 1'b1);
    end
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    expect_out("rst_mid", 8'h00, 8'h00, 0, 1'b0);
    ifc.req = '0;
    #3 rst_n = 1'b1;
    step("rst_idle0");
    step("rst_idle1");
    expect_out("rst_idle", 8'h00, 8'h00, 0, 1'b0);
    rr_req = '{8'h85, 8'h84, 8'h81, 8'h05};
    rr_exp = '{0, 2, 7, 0};
    for (int i = 0; i < 4; i++) begin
      ifc.req = rr_req[i];
      step("rr");
      expect_out($sformatf("rr%0d", i), 8'h10 + 8'(rr_exp[i]), 8'd1 << rr_exp[i], rr_exp[i], 1'b1);
    end
    ifc.req = 8'b0000_1000;
    step("own3");
    expect_out("own3c", 8'h13, 8'b0000_1000, 3, 1'b1);
    ifc.req = 8'b0100_0000;
    step("nobubble");
    expect_out("nobubble_c", 8'h16, 8'b0100_0000, 6, 1'b1);
    ifc.req = '0;
    step("drop");
    expect_out("drop_c", 8'h16, 8'h00, 6, 1'b0);
    ifc.req = 8'b0001_0000;
    step("own4");
    step("own4b");
    expect_out("own4c", 8'h14, 8'b0001_0000, 4, 1'b1);
    ifc.mode = MODE_DIRECT;
    ifc.sel = 3'd1;
    step("sw_dir");
    expect_out("sw_dir_c", 8'h11, 8'b0000_0010, 1, 1'b1);
    ifc.mode = MODE_ARB;
    step("sw_arb");
    expect_out("sw_arb_c", 8'h14, 8'b0001_0000, 4, 1'b1);
    for (int i = 0; i < 1500; i++) begin
      ifc.data_in = {$urandom, $urandom};
      ifc.mode = ($urandom_range(0, 11) == 0) ? MODE_DIRECT : MODE_ARB;
      ifc.sel = 3'($urandom);
      if ($urandom_range(0, 3) == 0) ifc.req = 8'($urandom) & 8'($urandom);
      else if ($urandom_range(0, 3) == 0) ifc.req = ifc.req ^ (8'd1 << $urandom_range(0, 7));
      step("rand");
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
